// File: rtl/audio_sequencer_pkg.sv
// Shared constants, FSM state type and helpers for the audio sequencer.
package audio_pkg;

   localparam int DEF_NUM_VOICES  = 2;
   localparam int DEF_SEQ_DEPTH   = 32;
   localparam int DEF_STEP_CYCLES = 12_000_000;
   localparam int DEF_DUTY_W      = 10;
   localparam int HP_W            = 18;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } seqState_e;

   typedef logic [HP_W-1:0] halfPeriod_t;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2Min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/audio_sequencer_if.sv
// Sequence-memory write bus: the host (master) loads half-periods per voice/step.
interface audio_sequencer_if #(
   parameter int NUM_VOICES = 2,
   parameter int SEQ_DEPTH  = 32,
   parameter int HP_W       = 18
);
   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int AW = $clog2(SEQ_DEPTH);

   logic            wr_en;
   logic [VW-1:0]   wr_voice;
   logic [AW-1:0]   wr_addr;
   logic [HP_W-1:0] wr_data;

   modport master (output wr_en, wr_voice, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_voice, wr_addr, wr_data);
endinterface

// File: rtl/audio_sequencer_voice.sv
// One square-wave voice: latches a half-period on step entry and toggles
// its output every hp+1 cycles while playing and unmuted.
module tone_voice #(
   parameter int HP_W = 18
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [HP_W-1:0] loadHp,
   input  logic            run,
   input  logic            enable,
   output logic            sq
);
   logic [HP_W-1:0] hp;
   logic [HP_W-1:0] toneCnt;

   // Step entry restarts the tone in phase; rests, mutes and idle hold it low.
   always_ff @(posedge clk) begin
      if (reset) begin
         hp      <= '0;
         toneCnt <= '0;
         sq      <= 1'b0;
      end else if (load) begin
         hp      <= loadHp;
         toneCnt <= '0;
         sq      <= 1'b0;
      end else if (!run || !enable || (hp == '0)) begin
         toneCnt <= '0;
         sq      <= 1'b0;
      end else if (toneCnt == hp) begin
         toneCnt <= '0;
         sq      <= ~sq;
      end else begin
         toneCnt <= toneCnt + HP_W'(1);
      end
   end
endmodule

// File: rtl/audio_sequencer.sv
// Multi-voice step sequencer: per-step half-periods drive square-wave voices
// that are summed and rendered as a single PWM output.
module audio_sequencer #(
   parameter int NUM_VOICES  = audio_pkg::DEF_NUM_VOICES,
   parameter int SEQ_DEPTH   = audio_pkg::DEF_SEQ_DEPTH,
   parameter int STEP_CYCLES = audio_pkg::DEF_STEP_CYCLES,
   parameter int HP_W        = audio_pkg::HP_W,
   parameter int DUTY_W      = audio_pkg::DEF_DUTY_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   input  logic [NUM_VOICES-1:0]        voice_en,
   audio_sequencer_if.slave             wrBus,
   output logic                         busy,
   output logic [$clog2(SEQ_DEPTH)-1:0] step_idx,
   output logic                         audioOut,
   output logic                         audioEn
);
   import audio_pkg::*;

   localparam int VW    = clog2Min1(NUM_VOICES);
   localparam int AW    = $clog2(SEQ_DEPTH);
   localparam int SC_W  = clog2Min1(STEP_CYCLES);
   localparam int CNT_W = $clog2(NUM_VOICES + 1);
   localparam int SH    = DUTY_W - $clog2(NUM_VOICES);

   seqState_e               state, stateNext;
   logic [SC_W-1:0]         stepCnt;
   logic                    stepDone, lastStep, stepLoad, runNext;
   logic [AW-1:0]           loadIdx;
   logic [NUM_VOICES-1:0]   sqVec;
   logic [CNT_W-1:0]        voiceCnt;
   logic [DUTY_W+CNT_W-1:0] dutyWide;
   logic [DUTY_W-1:0]       dutyNext, duty, pwmCnt;

   // Sequence memory, indexed [voice][step]; deliberately not reset.
   logic [HP_W-1:0] seqMem [NUM_VOICES][SEQ_DEPTH];

   // Host writes land at any time and are seen the next time the step loads.
   always_ff @(posedge clk) begin
      if (wrBus.wr_en) seqMem[wrBus.wr_voice][wrBus.wr_addr] <= wrBus.wr_data;
   end

   // Next-state and step-entry decode; stop beats start, start restarts.
   always_comb begin
      stepDone  = (stepCnt == SC_W'(STEP_CYCLES - 1));
      lastStep  = (step_idx == AW'(SEQ_DEPTH - 1));
      stateNext = state;
      stepLoad  = 1'b0;
      loadIdx   = step_idx + AW'(1);   // wraps to 0 at the last step
      if (stop) begin
         stateNext = IDLE;
      end else if (start) begin
         stateNext = PLAY;
         stepLoad  = 1'b1;
         loadIdx   = '0;
      end else if ((state == PLAY) && stepDone) begin
         if (lastStep && !loop_en) stateNext = IDLE;
         else                      stepLoad  = 1'b1;
      end
   end

   assign runNext = (stateNext == PLAY);
   assign busy    = (state == PLAY);
   assign audioEn = busy;

   // Step timing: the counter restarts on every step entry and idles at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         step_idx <= '0;
         stepCnt  <= '0;
      end else begin
         state <= stateNext;
         if (stepLoad) begin
            step_idx <= loadIdx;
            stepCnt  <= '0;
         end else if (stateNext == IDLE) begin
            step_idx <= '0;
            stepCnt  <= '0;
         end else begin
            stepCnt <= stepCnt + SC_W'(1);
         end
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : gVoice
      logic            wrHit;
      logic [HP_W-1:0] loadHp;

      // Write-first bypass so a write to the step being entered is heard now.
      always_comb begin
         wrHit  = wrBus.wr_en && (wrBus.wr_voice == VW'(v)) && (wrBus.wr_addr == loadIdx);
         loadHp = wrHit ? wrBus.wr_data : seqMem[v][loadIdx];
      end

      tone_voice #(.HP_W(HP_W)) uVoice (
         .clk    (clk),
         .reset  (reset),
         .load   (stepLoad),
         .loadHp (loadHp),
         .run    (runNext),
         .enable (voice_en[v]),
         .sq     (sqVec[v])
      );
   end

   // Mixer: count high voices, scale to full range and saturate.
   always_comb begin
      voiceCnt = '0;
      for (int i = 0; i < NUM_VOICES; i++) voiceCnt = voiceCnt + CNT_W'(sqVec[i]);
      dutyWide = {{DUTY_W{1'b0}}, voiceCnt} << SH;
      dutyNext = (|dutyWide[DUTY_W+CNT_W-1:DUTY_W]) ? '1 : dutyWide[DUTY_W-1:0];
   end

   // Registered duty, free-running PWM ramp and registered compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         duty     <= '0;
         pwmCnt   <= '0;
         audioOut <= 1'b0;
      end else begin
         duty     <= dutyNext;
         pwmCnt   <= (pwmCnt == '1) ? '0 : pwmCnt + DUTY_W'(1);
         audioOut <= (pwmCnt < duty);
      end
   end
endmodule

// File: tb/tb_audio_sequencer.sv
// Directed bench for audio_sequencer: tone periods, step timing, looping,
// start/stop priority, reset abort, write-first load and mixer duty.
module tb_audio_sequencer;
   localparam int NV = 2, SD = 4, SC = 100, HPW = 18, DW = 10;

   logic          clk = 1'b0;
   logic          reset, start, stop, loop_en;
   logic [NV-1:0] voice_en;
   logic          busy, audioOut, audioEn;
   logic [1:0]    step_idx;
   int            tests = 0, fails = 0;

   logic       sqH0 [0:499];
   logic       sqH1 [0:499];
   logic [1:0] idxH [0:499];
   logic       busyH[0:499];
   logic       enH  [0:499];
   logic       outH [0:499];
   logic [9:0] dutyH[0:499];

   audio_sequencer_if #(.NUM_VOICES(NV), .SEQ_DEPTH(SD), .HP_W(HPW)) wrBus ();

   audio_sequencer #(
      .NUM_VOICES(NV), .SEQ_DEPTH(SD), .STEP_CYCLES(SC), .HP_W(HPW), .DUTY_W(DW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
      .voice_en(voice_en), .wrBus(wrBus), .busy(busy), .step_idx(step_idx),
      .audioOut(audioOut), .audioEn(audioEn)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(input int k);
      sqH0[k] = dut.sqVec[0]; sqH1[k] = dut.sqVec[1]; idxH[k] = step_idx;
      busyH[k] = busy; enH[k] = audioEn; outH[k] = audioOut; dutyH[k] = dut.duty;
   endtask

   task automatic capture(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin tick(); snap(k); end
   endtask

   task automatic startPulse();
      start = 1'b1; tick(); start = 1'b0; snap(0);
   endtask

   task automatic stopPulse();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic wrMem(input int v, input int a, input int d);
      wrBus.wr_en = 1'b1; wrBus.wr_voice = 1'(v); wrBus.wr_addr = 2'(a); wrBus.wr_data = 18'(d);
      tick();
      wrBus.wr_en = 1'b0;
   endtask

   // Rising edges of one voice inside [lo,hi]: first time, count, uniform gap (-1 if uneven).
   task automatic rises(input int v, input int lo, input int hi,
                        output int first, output int cnt, output int gap);
      int  prev;
      logic cur, pre;
      first = -1; cnt = 0; gap = 0; prev = -1;
      for (int k = lo; k <= hi; k++) begin
         cur = (v == 0) ? sqH0[k]   : sqH1[k];
         pre = (v == 0) ? sqH0[k-1] : sqH1[k-1];
         if (cur && !pre) begin
            if (cnt == 0)              first = k;
            else if (cnt == 1)         gap = k - prev;
            else if (k - prev != gap)  gap = -1;
            prev = k;
            cnt++;
         end
      end
   endtask

   task automatic test_reset();
      int ones;
      reset = 1'b1; tick(); tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
      tests++; if (audioEn !== 1'b0) begin fails++; $display("FAIL rst_audioEn: got %b expected 0", audioEn); end
      tests++; if (step_idx !== 2'd0) begin fails++; $display("FAIL rst_step_idx: got %0d expected 0", step_idx); end
      tests++; if (audioOut !== 1'b0) begin fails++; $display("FAIL rst_audioOut: got %b expected 0", audioOut); end
      tests++; if (dut.duty !== 10'd0) begin fails++; $display("FAIL rst_duty: got %0d expected 0", dut.duty); end
      reset = 1'b0;
      ones = 0;
      for (int k = 0; k < 1030; k++) begin tick(); if (audioOut !== 1'b0) ones++; end
      tests++; if (ones != 0) begin fails++; $display("FAIL idle_pwm_silent: got %0d high cycles expected 0", ones); end
   endtask

   task automatic test_tone();
      int f, c, g, hi;
      wrMem(0, 0, 4); wrMem(0, 1, 9); wrMem(0, 2, 0); wrMem(0, 3, 4);
      wrMem(1, 0, 0); wrMem(1, 1, 0); wrMem(1, 2, 4); wrMem(1, 3, 0);
      loop_en = 1'b0; voice_en = 2'b11;
      startPulse(); capture(1, 401);
      rises(0, 1, 99, f, c, g);
      tests++; if (f != 5)  begin fails++; $display("FAIL tone_s0_first: got %0d expected 5", f); end
      tests++; if (c != 10) begin fails++; $display("FAIL tone_s0_count: got %0d expected 10", c); end
      tests++; if (g != 10) begin fails++; $display("FAIL tone_s0_period: got %0d expected 10", g); end
      rises(0, 100, 199, f, c, g);
      tests++; if (f != 110) begin fails++; $display("FAIL tone_s1_first: got %0d expected 110", f); end
      tests++; if (g != 20)  begin fails++; $display("FAIL tone_s1_period: got %0d expected 20", g); end
      hi = 0;
      for (int k = 200; k <= 299; k++) if (sqH0[k]) hi++;
      tests++; if (hi != 0) begin fails++; $display("FAIL tone_s2_rest: got %0d high cycles expected 0", hi); end
      tests++; if (idxH[99] !== 2'd0)  begin fails++; $display("FAIL step_k99: got %0d expected 0", idxH[99]); end
      tests++; if (idxH[100] !== 2'd1) begin fails++; $display("FAIL step_k100: got %0d expected 1", idxH[100]); end
      tests++; if (idxH[200] !== 2'd2) begin fails++; $display("FAIL step_k200: got %0d expected 2", idxH[200]); end
      tests++; if (idxH[300] !== 2'd3) begin fails++; $display("FAIL step_k300: got %0d expected 3", idxH[300]); end
      tests++; if (busyH[0] !== 1'b1)   begin fails++; $display("FAIL end_busy_k0: got %b expected 1", busyH[0]); end
      tests++; if (busyH[399] !== 1'b1) begin fails++; $display("FAIL end_busy_k399: got %b expected 1", busyH[399]); end
      tests++; if (busyH[400] !== 1'b0) begin fails++; $display("FAIL end_busy_k400: got %b expected 0", busyH[400]); end
      tests++; if (enH[400] !== 1'b0)   begin fails++; $display("FAIL end_audioEn_k400: got %b expected 0", enH[400]); end
   endtask

   task automatic test_loop();
      loop_en = 1'b1;
      startPulse(); capture(1, 401);
      tests++; if (idxH[399] !== 2'd3) begin fails++; $display("FAIL loop_k399: got %0d expected 3", idxH[399]); end
      tests++; if (idxH[400] !== 2'd0) begin fails++; $display("FAIL loop_wrap: got %0d expected 0", idxH[400]); end
      tests++; if (busyH[401] !== 1'b1) begin fails++; $display("FAIL loop_busy: got %b expected 1", busyH[401]); end
      stopPulse();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy: got %b expected 0", busy); end
      tests++; if (dut.sqVec !== 2'b00) begin fails++; $display("FAIL stop_sq: got %b expected 00", dut.sqVec); end
      loop_en = 1'b0;
   endtask

   task automatic test_start_stop();
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL startstop_busy: got %b expected 0", busy); end
      tick();
      tests++; if (audioEn !== 1'b0) begin fails++; $display("FAIL startstop_audioEn: got %b expected 0", audioEn); end
   endtask

   task automatic test_restart();
      int f, c, g;
      startPulse(); capture(1, 250);
      startPulse();
      tests++; if (step_idx !== 2'd0) begin fails++; $display("FAIL restart_idx: got %0d expected 0", step_idx); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b expected 1", busy); end
      capture(1, 120);
      rises(0, 1, 99, f, c, g);
      tests++; if (f != 5) begin fails++; $display("FAIL restart_first: got %0d expected 5", f); end
      tests++; if (idxH[100] !== 2'd1) begin fails++; $display("FAIL restart_step1: got %0d expected 1", idxH[100]); end
      stopPulse();
   endtask

   task automatic test_reset_mid();
      int f, c, g;
      startPulse(); capture(1, 207);
      tests++; if (dutyH[207] !== 10'd512) begin fails++; $display("FAIL mid_pre_duty: got %0d expected 512", dutyH[207]); end
      reset = 1'b1; tick(); reset = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
      tests++; if (audioEn !== 1'b0) begin fails++; $display("FAIL mid_audioEn: got %b expected 0", audioEn); end
      tests++; if (step_idx !== 2'd0) begin fails++; $display("FAIL mid_idx: got %0d expected 0", step_idx); end
      tests++; if (audioOut !== 1'b0) begin fails++; $display("FAIL mid_audioOut: got %b expected 0", audioOut); end
      tests++; if (dut.duty !== 10'd0) begin fails++; $display("FAIL mid_duty: got %0d expected 0", dut.duty); end
      startPulse(); capture(1, 199);
      rises(0, 1, 99, f, c, g);
      tests++; if (f != 5 || g != 10) begin fails++; $display("FAIL mid_replay_s0: got first %0d gap %0d expected 5 10", f, g); end
      rises(0, 100, 199, f, c, g);
      tests++; if (f != 110 || g != 20) begin fails++; $display("FAIL mid_replay_s1: got first %0d gap %0d expected 110 20", f, g); end
      stopPulse();
   endtask

   task automatic test_write_first();
      int f, c, g;
      startPulse(); capture(1, 99);
      wrBus.wr_en = 1'b1; wrBus.wr_voice = 1'b0; wrBus.wr_addr = 2'd1; wrBus.wr_data = 18'd14;
      capture(100, 100);
      wrBus.wr_en = 1'b0;
      capture(101, 199);
      rises(0, 100, 199, f, c, g);
      tests++; if (f != 115) begin fails++; $display("FAIL wf_first: got %0d expected 115", f); end
      tests++; if (g != 30 || c != 3) begin fails++; $display("FAIL wf_period: got gap %0d count %0d expected 30 3", g, c); end
      stopPulse();
      startPulse(); capture(1, 199);
      rises(0, 100, 199, f, c, g);
      tests++; if (f != 115) begin fails++; $display("FAIL wf_stored: got %0d expected 115", f); end
      stopPulse();
   endtask

   task automatic test_mixer();
      int ones, hi1;
      for (int v = 0; v < 2; v++) for (int a = 0; a < 4; a++) wrMem(v, a, 49);
      loop_en = 1'b1; voice_en = 2'b11;
      startPulse(); capture(1, 160);
      tests++; if (dutyH[30] !== 10'd0)     begin fails++; $display("FAIL mix2_low: got %0d expected 0", dutyH[30]); end
      tests++; if (dutyH[60] !== 10'd1023)  begin fails++; $display("FAIL mix2_high: got %0d expected 1023", dutyH[60]); end
      tests++; if (dutyH[100] !== 10'd1023) begin fails++; $display("FAIL mix2_k100: got %0d expected 1023", dutyH[100]); end
      tests++; if (dutyH[101] !== 10'd0)    begin fails++; $display("FAIL mix2_k101: got %0d expected 0", dutyH[101]); end
      tests++; if (dutyH[160] !== 10'd1023) begin fails++; $display("FAIL mix2_k160: got %0d expected 1023", dutyH[160]); end
      ones = 0;
      for (int k = 53; k <= 99; k++) if (outH[k]) ones++;
      tests++; if (ones < 46) begin fails++; $display("FAIL pwm_full: got %0d high of 47 expected at least 46", ones); end
      ones = 0;
      for (int k = 103; k <= 149; k++) if (outH[k]) ones++;
      tests++; if (ones != 0) begin fails++; $display("FAIL pwm_zero: got %0d high expected 0", ones); end
      voice_en = 2'b01;
      startPulse(); capture(1, 160);
      tests++; if (dutyH[30] !== 10'd0)    begin fails++; $display("FAIL mix1_low: got %0d expected 0", dutyH[30]); end
      tests++; if (dutyH[60] !== 10'd512)  begin fails++; $display("FAIL mix1_high: got %0d expected 512", dutyH[60]); end
      tests++; if (dutyH[160] !== 10'd512) begin fails++; $display("FAIL mix1_k160: got %0d expected 512", dutyH[160]); end
      hi1 = 0;
      for (int k = 1; k <= 160; k++) if (sqH1[k]) hi1++;
      tests++; if (hi1 != 0) begin fails++; $display("FAIL mix1_mute: got %0d high expected 0", hi1); end
      stopPulse();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; voice_en = '0;
      wrBus.wr_en = 1'b0; wrBus.wr_voice = '0; wrBus.wr_addr = '0; wrBus.wr_data = '0;
      test_reset();
      test_tone();
      test_loop();
      test_start_stop();
      test_restart();
      test_reset_mid();
      test_write_first();
      test_mixer();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/audio_sequencer.md
AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

Interface
REQ-001 Parameter NUM_VOICES, default 2, independent square-wave voices; legal values 1, 2, 4, 8.
REQ-002 Parameter SEQ_DEPTH, default 32, steps per voice sequence; power of two, at least 2.
REQ-003 Parameter STEP_CYCLES, default 12_000_000, clk cycles per sequence step.
REQ-004 Parameter HP_W, default 18, width of a half-period count.
REQ-005 Parameter DUTY_W, default 10, PWM resolution.
REQ-006 Ports: one clock and one reset; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock, 100 MHz.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 start  in  1  single-cycle pulse that begins playback from step 0.
REQ-010 stop  in  1  single-cycle pulse that aborts playback.
REQ-011 loop_en  in  1  when 1, the sequence wraps to step 0 after the last step.
REQ-012 voice_en  in  NUM_VOICES  per-voice mute mask; 0 mutes the voice.
REQ-013 wr_en  in  1  sequence-memory write strobe.
REQ-014 wr_voice  in  clog2(NUM_VOICES), minimum 1  voice selected for the write.
REQ-015 wr_addr  in  clog2(SEQ_DEPTH)  step selected for the write.
REQ-016 wr_data  in  HP_W  half-period in clk cycles minus 1; 0 encodes a rest.
REQ-017 busy  out  1  high while in PLAY.
REQ-018 step_idx  out  clog2(SEQ_DEPTH)  current step.
REQ-019 audioOut  out  1  PWM output.
REQ-020 audioEn  out  1  equals busy.

Function
REQ-021 FSM states are IDLE and PLAY.
REQ-022 In IDLE, start moves the FSM to PLAY on the next cycle, with step_idx=0 and step counter=0.
REQ-023 stop in any state forces IDLE on the next cycle; stop wins over a simultaneous start.
REQ-024 start asserted in PLAY restarts playback at step 0, with step counter and all voice counters cleared.
REQ-025 The step counter counts 0..STEP_CYCLES-1; at STEP_CYCLES-1, step_idx increments.
REQ-026 At step_idx=SEQ_DEPTH-1 with the counter expiring: loop_en=1 wraps step_idx to 0; loop_en=0 enters IDLE.
REQ-027 On every step entry, each voice loads its memory entry for the new step_idx, clears its tone counter and sets its square wave to 0.
REQ-028 A write to the same voice/address in the load cycle is write-first: the voice loads wr_data.
REQ-029 Writes are accepted in any state and take effect the next time that step is loaded.
REQ-030 Each voice with a nonzero half-period hp counts 0..hp and toggles its square wave when the count equals hp.
REQ-031 The resulting tone period is 2*(hp+1) clk cycles.
REQ-032 A voice with hp=0, voice_en=0, or the FSM in IDLE has its square wave forced to 0.
REQ-033 Mixer: n = number of voices whose square wave is high.
REQ-034 duty = n << (DUTY_W - clog2(NUM_VOICES)), saturated to 2^DUTY_W-1; duty is registered.
REQ-035 The PWM counter is a free-running DUTY_W-bit counter that wraps at 2^DUTY_W-1.
REQ-036 audioOut = (pwm_cnt < duty), registered.
REQ-037 Latency from a square-wave edge to the audioOut compare is 2 clk cycles.
REQ-038 When duty is 0, audioOut stays 0 for a full PWM period.
REQ-039 Arithmetic: all counters are unsigned and use wrap-free compare-to-limit; the step counter width is clog2(STEP_CYCLES).

Reset
REQ-040 On reset: state=IDLE, busy=0, audioEn=0, step_idx=0, audioOut=0, duty=0.
REQ-041 On reset, all counters and square-wave states are cleared.
REQ-042 Sequence memory is not cleared by reset; its contents are retained across reset.
REQ-043 Reset asserted mid-PLAY aborts playback; the next start after reset release begins at step 0.

Structure
REQ-044 Shared package audio_pkg holds the default parameter constants.
REQ-045 audio_pkg holds the FSM state enum and the half-period type width HP_W.
REQ-046 A sub-module tone_voice implements one voice (hp register, tone counter, square wave) and is instantiated NUM_VOICES times.
REQ-047 Sequence memory is one array of NUM_VOICES*SEQ_DEPTH entries of HP_W bits.

Verification
REQ-048 STEP_CYCLES=100, SEQ_DEPTH=4, voice0 entries {4,9,0,4}, start -> voice0 period 10 cycles in step 0, 20 cycles in step 1, silent in step 2; step_idx steps every 100 cycles.
REQ-049 loop_en=0, play to end -> busy and audioEn fall exactly 400 cycles after start+1; loop_en=1 -> step_idx wraps 3->0 and busy stays 1.
REQ-050 NUM_VOICES=2, both voices hp=49 in phase, voice_en=2'b11 -> duty alternates 1023 and 0; voice_en=2'b01 -> duty alternates 512 and 0.
REQ-051 start and stop asserted in the same cycle from IDLE -> stays IDLE, busy=0.
REQ-052 Reset pulse at step 2 -> all outputs 0 next cycle; memory retained; a new start replays from step 0 with the original tones.
REQ-053 Write to voice0 addr1 in the exact cycle step 1 loads -> the new value is played in step 1.
